// File: rtl/vmmu_pkg.sv
// Shared types and constants for the vmmu client read path: request FSM states,
// bytes-per-pixel and the RGB packing order.
package vmmu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StDrain = 2'd2
    } req_state_e;

    localparam int unsigned BPP       = 3;
    localparam int unsigned ByteWidth = 8;
    localparam int unsigned PixWidth  = BPP * ByteWidth;

    // First byte fetched (lowest address) lands in the top bits.
    function automatic logic [PixWidth-1:0] pack_rgb(input logic [ByteWidth-1:0] b0,
                                                     input logic [ByteWidth-1:0] b1,
                                                     input logic [ByteWidth-1:0] b2);
        return {b0, b1, b2};
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Byte collector for vmmu_scan_reader: pops bytes from the vmmu read FIFO, assembles
// 24-bit pixels and presents them on a valid/ready output register.
module pixel_packer
    import vmmu_pkg::*;
#(
    parameter int unsigned PWIDTH = 10,
    parameter int unsigned LWIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 en_i,
    input  logic [PWIDTH-1:0]    line_pixels_i,
    input  logic [LWIDTH-1:0]    frame_lines_i,
    input  logic                 empty_i,
    input  logic [ByteWidth-1:0] data_i,
    output logic                 pop_o,
    output logic                 rdclk_o,
    output logic [PixWidth-1:0]  pixel_o,
    output logic                 valid_o,
    output logic                 line_end_o,
    output logic                 frame_end_o,
    input  logic                 ready_i
);

    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [ByteWidth-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [PixWidth-1:0]  pixel_q, pixel_d;
    logic                 valid_q, valid_d;
    logic                 line_end_q, line_end_d;
    logic                 frame_end_q, frame_end_d;
    logic                 rdclk_q, rdclk_d;
    logic [PWIDTH-1:0]    pix_cnt_q, pix_cnt_d;
    logic [LWIDTH-1:0]    line_cnt_q, line_cnt_d;
    logic                 last_in_line;

    always_comb begin
        // Pop only when a completed pixel would have somewhere to go.
        pop_o        = en_i && !empty_i && !rdclk_q && (!valid_q || ready_i);
        rdclk_d      = pop_o;
        byte_idx_d   = byte_idx_q;
        slot0_d      = slot0_q;
        slot1_d      = slot1_q;
        pixel_d      = pixel_q;
        valid_d      = valid_q;
        line_end_d   = line_end_q;
        frame_end_d  = frame_end_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        last_in_line = pix_cnt_q == line_pixels_i - PWIDTH'(1);

        if (valid_q && ready_i) begin
            valid_d     = 1'b0;
            line_end_d  = 1'b0;
            frame_end_d = 1'b0;
        end
        if (start_i) begin
            byte_idx_d = 2'd0;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end
        if (pop_o) begin
            unique case (byte_idx_q)
                2'd0: begin
                    slot0_d    = data_i;
                    byte_idx_d = 2'd1;
                end
                2'd1: begin
                    slot1_d    = data_i;
                    byte_idx_d = 2'd2;
                end
                default: begin
                    pixel_d     = pack_rgb(slot0_q, slot1_q, data_i);
                    valid_d     = 1'b1;
                    line_end_d  = last_in_line;
                    frame_end_d = last_in_line && (line_cnt_q == frame_lines_i - LWIDTH'(1));
                    byte_idx_d  = 2'd0;
                    if (last_in_line) begin
                        pix_cnt_d  = '0;
                        line_cnt_d = line_cnt_q + LWIDTH'(1);
                    end else begin
                        pix_cnt_d  = pix_cnt_q + PWIDTH'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_q  <= 2'd0;
            slot0_q     <= '0;
            slot1_q     <= '0;
            pixel_q     <= '0;
            valid_q     <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            rdclk_q     <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            pixel_q     <= pixel_d;
            valid_q     <= valid_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
            rdclk_q     <= rdclk_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    assign rdclk_o     = rdclk_q;
    assign pixel_o     = pixel_q;
    assign valid_o     = valid_q;
    assign line_end_o  = line_end_q;
    assign frame_end_o = frame_end_q;

endmodule

// File: rtl/vmmu_scan_reader.sv
// Client read master walking a frame region through the vmmu read path.
// Define VMMU_SCAN_READER_STRIDE_EN to add a LineStride input for padded framebuffers.
module vmmu_scan_reader
    import vmmu_pkg::*;
#(
    parameter int unsigned AWIDTH      = 18,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAXINFLIGHT = 8,
    parameter int unsigned PWIDTH      = 10,
    parameter int unsigned LWIDTH      = 10
) (
    input  logic              MemClk,
    input  logic              ResetN,
    input  logic              FrameStart,
    input  logic [AWIDTH-1:0] BaseAddr,
    input  logic [PWIDTH-1:0] LinePixels,
    input  logic [LWIDTH-1:0] FrameLines,
`ifdef VMMU_SCAN_READER_STRIDE_EN
    input  logic [AWIDTH-1:0] LineStride,
`endif
    output logic [AWIDTH-1:0] ReadAddrOut,
    output logic              PushReadReq,
    input  logic              ReadReqQueueFull,
    input  logic [DWIDTH-1:0] ReadDataIn,
    input  logic              ReadDataQueueEmpty,
    output logic              ReadDataClkOut,
    output logic [23:0]       PixelData,
    output logic              PixelValid,
    input  logic              PixelReady,
    output logic              LineEnd,
    output logic              FrameEnd,
    output logic              Busy
);

    localparam int unsigned IfW = $clog2(MAXINFLIGHT + 1);

    req_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              push_q, push_d;
    logic [AWIDTH-1:0] addr_out_q, addr_out_d;
    logic [AWIDTH-1:0] next_addr_q, next_addr_d;
    logic [PWIDTH-1:0] pix_q, pix_d, lp_q, lp_d;
    logic [LWIDTH-1:0] line_q, line_d, fl_q, fl_d;
    logic [IfW-1:0]    inflight_q, inflight_d;
`ifdef VMMU_SCAN_READER_STRIDE_EN
    logic [AWIDTH-1:0] stride_q, stride_d, lstart_q, lstart_d, cur_lstart, cur_stride;
`endif

    logic              starting, issue, pop, credit_ok, last_pix, last_req;
    logic [AWIDTH-1:0] cur_addr;
    logic [PWIDTH-1:0] cur_pix, cur_lp;
    logic [LWIDTH-1:0] cur_line, cur_fl;

    always_comb begin
        // The first request goes out straight from IDLE using the live frame inputs.
        starting  = (state_q == StIdle) && FrameStart;
        cur_addr  = starting ? BaseAddr   : next_addr_q;
        cur_pix   = starting ? '0         : pix_q;
        cur_line  = starting ? '0         : line_q;
        cur_lp    = starting ? LinePixels : lp_q;
        cur_fl    = starting ? FrameLines : fl_q;
        credit_ok = ({1'b0, inflight_q} + (IfW+1)'(BPP)) <= (IfW+1)'(MAXINFLIGHT);
        issue     = (starting || state_q == StReq) && !ReadReqQueueFull && credit_ok && !push_q;
        last_pix  = cur_pix == cur_lp - PWIDTH'(1);
        last_req  = last_pix && (cur_line == cur_fl - LWIDTH'(1));

        state_d     = state_q;
        busy_d      = busy_q;
        push_d      = 1'b0;
        addr_out_d  = addr_out_q;
        next_addr_d = next_addr_q;
        pix_d       = pix_q;
        line_d      = line_q;
        lp_d        = lp_q;
        fl_d        = fl_q;
`ifdef VMMU_SCAN_READER_STRIDE_EN
        cur_lstart  = starting ? BaseAddr   : lstart_q;
        cur_stride  = starting ? LineStride : stride_q;
        stride_d    = stride_q;
        lstart_d    = lstart_q;
`endif

        if (starting) begin
            state_d     = StReq;
            busy_d      = 1'b1;
            lp_d        = LinePixels;
            fl_d        = FrameLines;
            next_addr_d = BaseAddr;
            pix_d       = '0;
            line_d      = '0;
`ifdef VMMU_SCAN_READER_STRIDE_EN
            stride_d    = LineStride;
            lstart_d    = BaseAddr;
`endif
        end

        if (issue) begin
            push_d     = 1'b1;
            addr_out_d = cur_addr;
            if (last_pix) begin
                pix_d  = '0;
                line_d = cur_line + LWIDTH'(1);
`ifdef VMMU_SCAN_READER_STRIDE_EN
                next_addr_d = cur_lstart + cur_stride;
                lstart_d    = cur_lstart + cur_stride;
`else
                next_addr_d = cur_addr + AWIDTH'(BPP);
`endif
            end else begin
                pix_d       = cur_pix + PWIDTH'(1);
                next_addr_d = cur_addr + AWIDTH'(BPP);
            end
            if (last_req) begin
                state_d = StDrain;
            end
        end

        if (state_q == StDrain && PixelValid && PixelReady && FrameEnd) begin
            state_d = StIdle;
            busy_d  = 1'b0;
        end

        inflight_d = inflight_q + (issue ? IfW'(BPP) : IfW'(0)) - (pop ? IfW'(1) : IfW'(0));
    end

    always_ff @(posedge MemClk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            push_q      <= 1'b0;
            addr_out_q  <= '0;
            next_addr_q <= '0;
            pix_q       <= '0;
            line_q      <= '0;
            lp_q        <= '0;
            fl_q        <= '0;
            inflight_q  <= '0;
`ifdef VMMU_SCAN_READER_STRIDE_EN
            stride_q    <= '0;
            lstart_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            push_q      <= push_d;
            addr_out_q  <= addr_out_d;
            next_addr_q <= next_addr_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            lp_q        <= lp_d;
            fl_q        <= fl_d;
            inflight_q  <= inflight_d;
`ifdef VMMU_SCAN_READER_STRIDE_EN
            stride_q    <= stride_d;
            lstart_q    <= lstart_d;
`endif
        end
    end

    pixel_packer #(
        .PWIDTH (PWIDTH),
        .LWIDTH (LWIDTH)
    ) u_packer (
        .clk_i         (MemClk),
        .rst_ni        (ResetN),
        .start_i       (starting),
        .en_i          (inflight_q != '0),
        .line_pixels_i (lp_q),
        .frame_lines_i (fl_q),
        .empty_i       (ReadDataQueueEmpty),
        .data_i        (ReadDataIn),
        .pop_o         (pop),
        .rdclk_o       (ReadDataClkOut),
        .pixel_o       (PixelData),
        .valid_o       (PixelValid),
        .line_end_o    (LineEnd),
        .frame_end_o   (FrameEnd),
        .ready_i       (PixelReady)
    );

    assign ReadAddrOut = addr_out_q;
    assign PushReadReq = push_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_vmmu_scan_reader.sv
// Randomized self-checking bench for vmmu_scan_reader with a behavioural vmmu and
// a frame-level reference model of request addresses and output pixels.
module tb_vmmu_scan_reader;

    logic        MemClk = 1'b0;
    logic        ResetN;
    logic        FrameStart;
    logic [17:0] BaseAddr;
    logic [9:0]  LinePixels;
    logic [9:0]  FrameLines;
    logic [17:0] LineStride;
    logic [17:0] ReadAddrOut;
    logic        PushReadReq;
    logic        ReadReqQueueFull;
    logic [7:0]  ReadDataIn;
    logic        ReadDataQueueEmpty;
    logic        ReadDataClkOut;
    logic [23:0] PixelData;
    logic        PixelValid;
    logic        PixelReady;
    logic        LineEnd;
    logic        FrameEnd;
    logic        Busy;

    vmmu_scan_reader dut (
        .MemClk             (MemClk),
        .ResetN             (ResetN),
        .FrameStart         (FrameStart),
        .BaseAddr           (BaseAddr),
        .LinePixels         (LinePixels),
        .FrameLines         (FrameLines),
`ifdef VMMU_SCAN_READER_STRIDE_EN
        .LineStride         (LineStride),
`endif
        .ReadAddrOut        (ReadAddrOut),
        .PushReadReq        (PushReadReq),
        .ReadReqQueueFull   (ReadReqQueueFull),
        .ReadDataIn         (ReadDataIn),
        .ReadDataQueueEmpty (ReadDataQueueEmpty),
        .ReadDataClkOut     (ReadDataClkOut),
        .PixelData          (PixelData),
        .PixelValid         (PixelValid),
        .PixelReady         (PixelReady),
        .LineEnd            (LineEnd),
        .FrameEnd           (FrameEnd),
        .Busy               (Busy)
    );

    always #5 MemClk = ~MemClk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [17:0] exp_req[$];
    logic [25:0] exp_pix[$];
    logic [7:0]  fifo[$];
    logic [7:0]  salt = 8'h00;
    int          outstanding = 0;
    int          push_cnt = 0;
    int          ready_pct = 100;
    int          full_pct = 0;
    bit          hold_full = 1'b0;
    bit          hold_stall = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [17:0] a);
        return a[7:0] ^ salt;
    endfunction

    // Behavioural vmmu plus output monitor; all DUT outputs are stable at the falling edge.
    always @(negedge MemClk) begin : vmmu_model
        logic        full_prev, prev_push, held_prev;
        logic [17:0] last_addr, a;
        logic [25:0] held_word, w;
        full_prev = ReadReqQueueFull;
        ReadReqQueueFull = hold_full || ($urandom_range(99) < full_pct);
        PixelReady = !hold_stall && ($urandom_range(99) < ready_pct);
        if (!ResetN) begin
            fifo.delete();
            exp_req.delete();
            exp_pix.delete();
            outstanding = 0;
            prev_push = 1'b0;
            held_prev = 1'b0;
        end else begin
            if (prev_push) check_val("addr_hold", ReadAddrOut, last_addr);
            if (PushReadReq && !prev_push) begin
                push_cnt++;
                check_val("push_while_full", full_prev, 0);
                if (exp_req.size() != 0) check_val("req_addr", ReadAddrOut, exp_req.pop_front());
                else check_val("req_extra", ReadAddrOut, 32'hFFFF_FFFF);
                for (int k = 0; k < 3; k++) begin
                    a = ReadAddrOut + 18'(k);
                    fifo.push_back(mem_byte(a));
                end
                outstanding += 3;
                check_val("inflight_cap", outstanding <= 8, 1);
                last_addr = ReadAddrOut;
            end
            if (ReadDataClkOut) begin
                check_val("pop_nonempty", fifo.size() != 0, 1);
                if (fifo.size() != 0) void'(fifo.pop_front());
                outstanding -= 1;
            end
            if (held_prev) begin
                check_val("hold_valid", PixelValid, 1);
                check_val("hold_data", {FrameEnd, LineEnd, PixelData}, held_word);
            end
            w = {FrameEnd, LineEnd, PixelData};
            if (PixelValid && PixelReady) begin
                if (exp_pix.size() != 0) check_val("pixel", w, exp_pix.pop_front());
                else check_val("pixel_extra", w, 32'hFFFF_FFFF);
                if (FrameEnd) check_val("busy_at_last", Busy, 1);
            end
            held_prev = PixelValid && !PixelReady;
            held_word = w;
            prev_push = PushReadReq;
        end
        ReadDataQueueEmpty = fifo.size() == 0;
        ReadDataIn = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic start_frame(input logic [17:0] base, input int lp, input int fl,
                               input logic [17:0] stride);
        int          line_bytes;
        logic [17:0] a;
`ifdef VMMU_SCAN_READER_STRIDE_EN
        line_bytes = int'(stride);
`else
        line_bytes = 3 * lp;
`endif
        for (int l = 0; l < fl; l++) begin
            for (int p = 0; p < lp; p++) begin
                a = 18'(int'(base) + l * line_bytes + 3 * p);
                exp_req.push_back(a);
                exp_pix.push_back({(l == fl - 1) && (p == lp - 1), p == lp - 1,
                                   mem_byte(a), mem_byte(a + 18'd1), mem_byte(a + 18'd2)});
            end
        end
        BaseAddr   = base;
        LinePixels = 10'(lp);
        FrameLines = 10'(fl);
        LineStride = stride;
        FrameStart = 1'b1;
        @(posedge MemClk);
        #1 FrameStart = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 20000) begin
            @(posedge MemClk);
            #1 n++;
        end
        check_val("frame_done", Busy, 0);
        check_val("req_left", exp_req.size(), 0);
        check_val("pix_left", exp_pix.size(), 0);
        exp_req.delete();
        exp_pix.delete();
    endtask

    task automatic check_reset_outputs();
        check_val("rst_push", PushReadReq, 0);
        check_val("rst_rdclk", ReadDataClkOut, 0);
        check_val("rst_valid", PixelValid, 0);
        check_val("rst_line_end", LineEnd, 0);
        check_val("rst_frame_end", FrameEnd, 0);
        check_val("rst_busy", Busy, 0);
        check_val("rst_addr", ReadAddrOut, 0);
        check_val("rst_data", PixelData, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0;
        ResetN = 1'b0;
        FrameStart = 1'b0;
        BaseAddr = '0;
        LinePixels = '0;
        FrameLines = '0;
        LineStride = '0;
        ReadReqQueueFull = 1'b0;
        ReadDataQueueEmpty = 1'b1;
        ReadDataIn = '0;
        PixelReady = 1'b1;
        repeat (3) @(posedge MemClk);
        #1 check_reset_outputs();
        ResetN = 1'b1;
        @(posedge MemClk);
        #1;

        // Basic 4x2 frame, byte = addr[7:0]; a FrameStart mid-frame must be ignored.
        start_frame(18'h00100, 4, 2, 18'h0);
        check_val("busy_rise", Busy, 1);
        check_val("first_push", PushReadReq, 1);
        check_val("first_addr", ReadAddrOut, 18'h00100);
        repeat (5) @(posedge MemClk);
        #1 BaseAddr = 18'h2A000;
        FrameStart = 1'b1;
        @(posedge MemClk);
        #1 FrameStart = 1'b0;
        wait_idle();

        // Downstream stall mid-frame: credits saturate and output holds.
        salt = 8'($urandom);
        start_frame(18'($urandom), 8, 4, 18'h0);
        n = 0;
        while (exp_pix.size() > 27 && n < 2000) begin
            @(posedge MemClk);
            n++;
        end
        hold_stall = 1'b1;
        repeat (50) @(negedge MemClk);
        #1 check_val("inflight_sat", outstanding, 6);
        @(posedge MemClk);
        hold_stall = 1'b0;
        wait_idle();

        // Request queue full for 20 cycles mid-frame.
        ready_pct = 70;
        salt = 8'($urandom);
        start_frame(18'($urandom), 6, 3, 18'h0);
        repeat (12) @(posedge MemClk);
        hold_full = 1'b1;
        @(negedge MemClk);
        #1 c0 = push_cnt;
        repeat (20) @(negedge MemClk);
        #1 check_val("no_push_full", push_cnt - c0, 0);
        @(posedge MemClk);
        hold_full = 1'b0;
        wait_idle();

        // Address wrap modulo 2^18.
        salt = 8'h5A;
        start_frame(18'h3FFFE, 2, 1, 18'h0);
        wait_idle();

        // Reset mid-frame, then restart from a new base.
        full_pct = 15;
        start_frame(18'($urandom), 6, 3, 18'h0);
        repeat (15) @(posedge MemClk);
        #2 ResetN = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge MemClk);
        #2 ResetN = 1'b1;
        @(posedge MemClk);
        #1 salt = 8'($urandom);
        start_frame(18'($urandom), 5, 2, 18'h0);
        wait_idle();

`ifdef VMMU_SCAN_READER_STRIDE_EN
        salt = 8'h00;
        start_frame(18'h00000, 2, 2, 18'h00040);
        wait_idle();
`endif

        // Random frames, including 1x1.
        for (int i = 0; i < 12; i++) begin
            ready_pct = 40 + int'($urandom_range(60));
            full_pct = int'($urandom_range(30));
            salt = 8'($urandom);
            start_frame(18'($urandom), (i == 0) ? 1 : 1 + int'($urandom_range(5)),
                        (i == 0) ? 1 : 1 + int'($urandom_range(3)), 18'h0);
            wait_idle();
            @(posedge MemClk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
